dmem_arbiter: RTL and testbench

Shares the single data-memory/peripheral port between the pipeline CPU's MEM stage (port 0) and a secondary bus master such as a UART loader or DMA engine (port 1). The CPU has priority. A starvation counter guarantees port 1 progress. The block sits between the EX/MEM register outputs and the data memory/peripheral decode. It drives a stall that freezes the pipeline, the same way the load-use hazard freeze does.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arb_starve.sv | 40 ++++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: port IDs, starve-counter
// width and the command encoding used on the shared memory port.
package dmem_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_D   = 1'b1;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  // A simultaneous read+write request is resolved as a write.
  function automatic cmd_e cmd_decode(input logic rd, input logic wr);
    if (wr) begin
      return CMD_WRITE;
    end else if (rd) begin
      return CMD_READ;
    end
    return CMD_IDLE;
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating starvation counter for the secondary port; d_force asks the
// arbiter to pre-empt the CPU once port 1 has waited STARVE_LIMIT cycles.
module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_req,
  input  logic d_gnt,
  output logic d_force
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (d_gnt) begin
      cnt_d = '0;
    end else if (d_req && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only a live request may force; a withdrawn request leaves the CPU free to run.
  assign d_force = d_req && (cnt_q >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline MEM stage (priority) and a secondary
// bus master. Optional statistics counters are enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_stall,
  output logic [31:0]       stat_d_grant
`endif
);

  cmd_e cpu_cmd;
  cmd_e d_cmd;
  cmd_e issue_cmd;
  logic gnt_port;
  logic cpu_gnt;
  logic d_force;

  logic              cpu_rsp_q, cpu_rsp_d;
  logic              d_rsp_q, d_rsp_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  dmem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .d_req  (d_req),
    .d_gnt  (d_gnt),
    .d_force(d_force)
  );

  // While a CPU read response is owed, the frozen CPU request is not reissued.
  always_comb begin
    cpu_cmd   = cmd_decode(cpu_rd, cpu_wr);
    d_cmd     = d_req ? (d_we ? CMD_WRITE : CMD_READ) : CMD_IDLE;
    issue_cmd = CMD_IDLE;
    gnt_port  = PORT_CPU;
    cpu_gnt   = 1'b0;
    d_gnt     = 1'b0;
    cpu_stall = 1'b0;
    if (reset) begin
      if ((cpu_cmd != CMD_IDLE) && !cpu_rsp_q && !d_force) begin
        cpu_gnt   = 1'b1;
        issue_cmd = cpu_cmd;
        cpu_stall = (cpu_cmd == CMD_READ);
      end else if (d_req) begin
        d_gnt     = 1'b1;
        gnt_port  = PORT_D;
        issue_cmd = d_cmd;
        cpu_stall = (cpu_cmd != CMD_IDLE) && !cpu_rsp_q;
      end
    end
  end

  always_comb begin
    mem_rd    = (issue_cmd == CMD_READ);
    mem_wr    = (issue_cmd == CMD_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_cmd != CMD_IDLE) begin
      mem_addr = (gnt_port == PORT_D) ? d_addr : cpu_addr;
    end
    if (issue_cmd == CMD_WRITE) begin
      mem_wdata = (gnt_port == PORT_D) ? d_wdata : cpu_wdata;
    end
  end

  always_comb begin
    cpu_rsp_d   = cpu_gnt && (issue_cmd == CMD_READ);
    d_rsp_d     = d_gnt && (issue_cmd == CMD_READ);
    cpu_rdata_d = cpu_rsp_q ? mem_rdata : cpu_rdata_q;
    d_rdata_d   = d_rsp_q ? mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rsp_q   <= 1'b0;
      d_rsp_q     <= 1'b0;
      cpu_rdata_q <= '0;
      d_rdata_q   <= '0;
    end else begin
      cpu_rsp_q   <= cpu_rsp_d;
      d_rsp_q     <= d_rsp_d;
      cpu_rdata_q <= cpu_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Read data is passed straight through in the response cycle, held otherwise.
  assign cpu_rdata = cpu_rdata_d;
  assign d_rdata   = d_rdata_d;
  assign d_rvalid  = d_rsp_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (cpu_stall ? 32'd1 : 32'd0);
    grant_cnt_d = grant_cnt_q + (d_gnt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stat_cpu_stall = stall_cnt_q;
  assign stat_d_grant   = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous-read
// memory model; stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_gnt, d_rvalid;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall, stat_d_grant;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_stall(stat_cpu_stall),
    .stat_d_grant  (stat_d_grant)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    d_req     = dreq;
    d_we      = dwe;
    d_addr    = daddr;
    d_wdata   = dwdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pat_req [6];
    logic pat_gnt [6];
    pat_req = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    pat_gnt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h08] = 32'hDEADBEEF;
    mem[6'h10] = 32'hCAFEF00D;
    mem_rdata  = 32'h0;

    // Reset held with requests active: nothing may reach the memory port.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h11111111, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ctrl", {27'h0, mem_rd, mem_wr, d_gnt, cpu_stall, d_rvalid}, 32'h0);
      checkOutput("rst_addr", mem_addr, 32'h0);
      nextCycle();
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("first_wr", {30'h0, mem_wr, cpu_stall}, 32'h2);
    checkOutput("first_wr_addr", mem_addr, 32'h10);
    checkOutput("first_wr_data", mem_wdata, 32'h11111111);

    // Plain CPU read: one stall cycle, data in the following cycle.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_issue", {30'h0, mem_rd, cpu_stall}, 32'h3);
    checkOutput("rd_addr", mem_addr, 32'h20);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_rsp", {30'h0, mem_rd, cpu_stall}, 32'h0);
    checkOutput("rd_data", cpu_rdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_hold", cpu_rdata, 32'hDEADBEEF);

    // Starvation: CPU writes every cycle, port 1 read wins on the 5th cycle.
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h80808080, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("starve_c%0d", i), {29'h0, d_gnt, cpu_stall, mem_wr}, 32'h1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("starve_gnt", {28'h0, d_gnt, cpu_stall, mem_rd, mem_wr}, 32'hE);
    checkOutput("starve_addr", mem_addr, 32'h40);
    nextCycle();
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("starve_rvalid", {29'h0, d_rvalid, cpu_stall, mem_wr}, 32'h5);
    checkOutput("starve_rdata", d_rdata, 32'hCAFEF00D);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stat_stall", stat_cpu_stall, 32'd2);
    checkOutput("stat_grant", stat_d_grant, 32'd1);
`endif

    // Counter restarts from zero after the grant and holds while withdrawn.
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      d_req = pat_req[i];
      @(negedge clk);
      checkOutput($sformatf("withdraw_c%0d", i), {31'h0, d_gnt}, {31'h0, pat_gnt[i]});
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("withdraw_rvalid", {31'h0, d_rvalid}, 32'h1);
    checkOutput("withdraw_rdata", d_rdata, 32'hCAFEF00D);

    // Port-1 write with CPU idle, then CPU reads it back.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h5A5A5A5A);
    @(negedge clk);
    checkOutput("dwr_ctrl", {29'h0, d_gnt, mem_wr, mem_rd}, 32'h6);
    checkOutput("dwr_addr", mem_addr, 32'h44);
    checkOutput("dwr_data", mem_wdata, 32'h5A5A5A5A);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("dwr_no_rvalid", {30'h0, d_rvalid, cpu_stall}, 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("dwr_readback", cpu_rdata, 32'h5A5A5A5A);

    // Read and write together is a write.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h48, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rdwr_ctrl", {29'h0, mem_rd, mem_wr, cpu_stall}, 32'h2);
    checkOutput("rdwr_data", mem_wdata, 32'h12345678);

    // CPU read and port-1 request arrive together: port 1 follows in the response cycle.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("share_n_ctrl", {29'h0, d_gnt, cpu_stall, mem_rd}, 32'h3);
    checkOutput("share_n_addr", mem_addr, 32'h20);
    nextCycle();
    @(negedge clk);
    checkOutput("share_n1_ctrl", {29'h0, d_gnt, cpu_stall, mem_rd}, 32'h5);
    checkOutput("share_n1_addr", mem_addr, 32'h40);
    checkOutput("share_n1_cpu", cpu_rdata, 32'hDEADBEEF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("share_n2_ctrl", {30'h0, d_rvalid, mem_rd}, 32'h2);
    checkOutput("share_n2_data", d_rdata, 32'hCAFEF00D);

    // Reset right after a port-1 read grant drops the pending response.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checkOutput("rst_pend_gnt", {31'h0, d_gnt}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("rst_async_data", d_rdata | cpu_rdata, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_pend_rvalid", {31'h0, d_rvalid}, 32'h0);
      nextCycle();
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_after_rvalid", {31'h0, d_rvalid}, 32'h0);
    checkOutput("rst_after_rdata", d_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stat_clear", stat_cpu_stall | stat_d_grant, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
